// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Each operation takes IDLE -> EXEC -> RESP; the response is held until consumed.
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [5:0]       req0_opcode,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [5:0]       req1_opcode,
    input  logic             req1_cin,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [5:0]       alu_opcode,
    output logic             alu_cin,
    input  logic [31:0]      alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic [5:0] OP_NOP = 6'b111111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  opcode;
        logic        cin;
        logic        id;
    } req_t;

    typedef struct packed {
        logic        id;
        logic [31:0] result;
        logic [3:0]  flags;
    } rsp_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    req_t            req_q, req_d;
    rsp_t            rsp_q, rsp_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic grant_vld;
    logic grant_id;
    logic accept;

    // With both requesters pending, the one not served last wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~last_grant_q;
        end else if (req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
        end else if (req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
        end
    end

    assign accept     = (state_q == IDLE) && grant_vld && !rst;
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_d        = req_q;
        rsp_d        = rsp_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d        = grant_id ? {req1_a, req1_b, req1_opcode, req1_cin, 1'b1}
                                            : {req0_a, req0_b, req0_opcode, req0_cin, 1'b0};
                    last_grant_d = grant_id;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_d   = '{id: req_q.id, result: alu_result, flags: alu_flags};
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (rsp_q.id) cnt1_d = cnt1_q + CNT_W'(1);
                    else          cnt0_d = cnt0_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            req_q        <= '0;
            rsp_q        <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
            rsp_q        <= rsp_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    // The ALU only sees a real operation during EXEC; otherwise it idles on NOP.
    assign alu_a      = (state_q == EXEC) ? req_q.a      : 32'd0;
    assign alu_b      = (state_q == EXEC) ? req_q.b      : 32'd0;
    assign alu_opcode = (state_q == EXEC) ? req_q.opcode : OP_NOP;
    assign alu_cin    = (state_q == EXEC) ? req_q.cin    : 1'b0;

    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_q.id;
    assign rsp_result = rsp_q.result;
    assign rsp_flags  = rsp_q.flags;
    assign cnt0       = cnt0_q;
    assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, corner sequences, and a
// randomized run scored against a transaction-level model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0_valid, req1_valid, req0_cin, req1_cin, rsp_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [5:0]  req0_opcode, req1_opcode;

    logic        req0_ready, req1_ready, alu_cin, rsp_valid, rsp_id;
    logic [31:0] alu_a, alu_b, alu_result, rsp_result;
    logic [5:0]  alu_opcode;
    logic [3:0]  alu_flags, rsp_flags;
    logic [15:0] cnt0, cnt1;

    logic        n_req0_ready, n_req1_ready, n_alu_cin, n_rsp_valid, n_rsp_id;
    logic [31:0] n_alu_a, n_alu_b, n_alu_result, n_rsp_result;
    logic [5:0]  n_alu_opcode;
    logic [3:0]  n_alu_flags, n_rsp_flags;
    logic [1:0]  n_cnt0, n_cnt1;

    int n_pass  = 0;
    int n_total = 0;

    // Environment ALU: opcode 0 is ADD with carry-in; any other opcode returns a^b.
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [5:0] op, input logic cin);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        if (op == 6'd0) begin
            s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            r = s[31:0];
            c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
        end else begin
            r = a ^ b;
        end
        return {(r == 32'd0), r[31], c, v, r};
    endfunction

    logic [35:0] alu_flat, n_alu_flat;
    always_comb alu_flat   = alu_fn(alu_a, alu_b, alu_opcode, alu_cin);
    always_comb n_alu_flat = alu_fn(n_alu_a, n_alu_b, n_alu_opcode, n_alu_cin);
    assign alu_result   = alu_flat[31:0];
    assign alu_flags    = alu_flat[35:32];
    assign n_alu_result = n_alu_flat[31:0];
    assign n_alu_flags  = n_alu_flat[35:32];

    alu_arbiter #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_opcode(req0_opcode), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_opcode(req1_opcode), .req1_cin(req1_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .cnt0(cnt0), .cnt1(cnt1)
    );

    // Narrow-counter instance in lockstep, used for wrap checks.
    alu_arbiter #(.CNT_W(2)) u_dut_narrow (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(n_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_opcode(req0_opcode), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(n_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_opcode(req1_opcode), .req1_cin(req1_cin),
        .alu_a(n_alu_a), .alu_b(n_alu_b), .alu_opcode(n_alu_opcode), .alu_cin(n_alu_cin),
        .alu_result(n_alu_result), .alu_flags(n_alu_flags),
        .rsp_valid(n_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(n_rsp_id),
        .rsp_result(n_rsp_result), .rsp_flags(n_rsp_flags), .cnt0(n_cnt0), .cnt1(n_cnt1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_a = 0; req0_b = 0; req0_opcode = 0; req0_cin = 0;
        req1_a = 0; req1_b = 0; req1_opcode = 0; req1_cin = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic set_req(input logic id, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] op, input logic cin);
        req0_valid = !id;
        req1_valid = id;
        if (id) begin
            req1_a = a; req1_b = b; req1_opcode = op; req1_cin = cin;
        end else begin
            req0_a = a; req0_b = b; req0_opcode = op; req0_cin = cin;
        end
    endtask

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic        cin;
        logic [31:0] exp_res;
        logic [3:0]  exp_flg;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic        cin;
        logic [35:0] out;
    } txn_t;

    vec_t vecs[5];

    initial begin
        int exp_cnt[2];
        logic [1:0] wrap_exp[4];
        txn_t        q[$];
        txn_t        t;
        int          m_age;
        logic        m_last;
        int unsigned m_cnt[2];
        logic        in_flight, exp_r0, exp_r1, exp_rv;
        logic [5:0]  exp_op;
        logic [31:0] exp_a;

        vecs[0] = '{1'b0, 32'd5,          32'd7,          6'd0,  1'b0, 32'd12,         4'b0000};
        vecs[1] = '{1'b1, 32'h7FFF_FFFF,  32'd1,          6'd0,  1'b0, 32'h8000_0000,  4'b0101};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          6'd0,  1'b0, 32'd0,          4'b1010};
        vecs[3] = '{1'b1, 32'd1,          32'd2,          6'd0,  1'b1, 32'd4,          4'b0000};
        vecs[4] = '{1'b0, 32'hF0F0_F0F0,  32'h0F0F_0F0F,  6'h2A, 1'b1, 32'hFFFF_FFFF,  4'b0100};
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0};

        // Reset behaviour: readys held low while rst is high, clean outputs after.
        idle_inputs();
        rst = 1;
        req0_valid = 1; req1_valid = 1;
        #1;
        check("ready_in_reset", {req1_ready, req0_ready}, 2'b00);
        tick();
        tick();
        rst = 0;
        req0_valid = 0; req1_valid = 0;
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_flags", rsp_flags, 4'd0);
        check("rst_alu_opcode", alu_opcode, 6'h3F);
        check("rst_alu_ab", {alu_a, alu_b}, 64'd0);
        check("rst_cnt", {cnt0, cnt1}, 32'd0);

        // Directed vector table, single requester per op.
        exp_cnt = '{0, 0};
        for (int i = 0; i < 5; i++) begin
            set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin);
            #1;
            check("vec_ready", {req1_ready, req0_ready}, vecs[i].id ? 2'b10 : 2'b01);
            tick();
            set_req(vecs[i].id, $urandom, $urandom, 6'h15, 1'b0);
            req0_valid = 0; req1_valid = 0;
            #1;
            check("vec_exec_ready", {req1_ready, req0_ready}, 2'b00);
            check("vec_alu_opcode", alu_opcode, vecs[i].op);
            check("vec_alu_ab", {alu_a, alu_b}, {vecs[i].a, vecs[i].b});
            check("vec_alu_cin", alu_cin, vecs[i].cin);
            check("vec_exec_rsp_valid", rsp_valid, 1'b0);
            tick();
            check("vec_rsp_valid", rsp_valid, 1'b1);
            check("vec_rsp_id", rsp_id, vecs[i].id);
            check("vec_rsp_result", rsp_result, vecs[i].exp_res);
            check("vec_rsp_flags", rsp_flags, vecs[i].exp_flg);
            check("vec_resp_alu_op", alu_opcode, 6'h3F);
            rsp_ready = 1;
            tick();
            rsp_ready = 0;
            exp_cnt[vecs[i].id]++;
            check("vec_rsp_done", rsp_valid, 1'b0);
            check("vec_cnt0", cnt0, 16'(exp_cnt[0]));
            check("vec_cnt1", cnt1, 16'(exp_cnt[1]));
        end

        // Tie after reset: grants alternate 0,1,0,1 at one op per 3 cycles.
        do_reset();
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("tie_grant", {req1_ready, req0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            check("tie_exec_ready", {req1_ready, req0_ready}, 2'b00);
            tick();
            check("tie_resp_valid", rsp_valid, 1'b1);
            if (k == 3) begin
                req0_valid = 0; req1_valid = 0;
            end
            tick();
        end
        rsp_ready = 0;
        check("tie_cnt0", cnt0, 16'd2);
        check("tie_cnt1", cnt1, 16'd2);

        // Backpressure: response held stable while the consumer stalls.
        do_reset();
        set_req(1'b0, 32'd3, 32'd4, 6'd0, 1'b0);
        #1;
        check("bp_accept", {req1_ready, req0_ready}, 2'b01);
        tick();
        req1_valid = 1;
        tick();
        for (int c = 0; c < 5; c++) begin
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rsp_hold", {rsp_id, rsp_result, rsp_flags}, {1'b0, 32'd7, 4'b0000});
            check("bp_readys", {req1_ready, req0_ready}, 2'b00);
            tick();
        end
        check("bp_cnt_held", cnt0, 16'd0);
        rsp_ready = 1;
        #1;
        check("bp_release_valid", rsp_valid, 1'b1);
        tick();
        rsp_ready = 0;
        check("bp_back_idle", {req1_ready, req0_ready}, 2'b10);
        check("bp_cnt0", cnt0, 16'd1);
        req0_valid = 0; req1_valid = 0;
        tick();

        // Reset during EXEC discards the in-flight op.
        do_reset();
        set_req(1'b1, 32'd9, 32'd9, 6'd0, 1'b0);
        #1;
        check("rx_accept", {req1_ready, req0_ready}, 2'b10);
        tick();
        rst = 1;
        req0_valid = 1; req1_valid = 1;
        #1;
        check("rx_ready_in_reset", {req1_ready, req0_ready}, 2'b00);
        tick();
        rst = 0;
        req0_valid = 0; req1_valid = 0;
        rsp_ready = 1;
        check("rx_alu_opcode", alu_opcode, 6'h3F);
        check("rx_rsp_regs", {rsp_id, rsp_result, rsp_flags}, 37'd0);
        for (int c = 0; c < 3; c++) begin
            check("rx_no_rsp", rsp_valid, 1'b0);
            tick();
        end
        check("rx_cnt", {cnt0, cnt1}, 32'd0);
        req0_valid = 1; req1_valid = 1;
        #1;
        check("rx_tie_req0", {req1_ready, req0_ready}, 2'b01);
        req0_valid = 0; req1_valid = 0;
        rsp_ready = 0;
        tick();

        // Counter wrap on the 2-bit instance.
        do_reset();
        check("wrap_start", n_cnt0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            set_req(1'b0, 32'(k), 32'd1, 6'd0, 1'b0);
            tick();
            req0_valid = 0;
            tick();
            rsp_ready = 1;
            tick();
            rsp_ready = 0;
            check("wrap_cnt0", n_cnt0, wrap_exp[k]);
        end

        // Randomized run against a transaction-level model.
        do_reset();
        q.delete();
        m_age  = 0;
        m_last = 1'b1;
        m_cnt  = '{0, 0};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst         = ($urandom_range(0, 79) == 0);
            req0_valid  = $urandom_range(0, 1) == 1;
            req1_valid  = $urandom_range(0, 1) == 1;
            req0_a      = $urandom;  req0_b = $urandom;
            req1_a      = $urandom;  req1_b = $urandom;
            req0_opcode = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            req1_opcode = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            req0_cin    = $urandom_range(0, 1) == 1;
            req1_cin    = $urandom_range(0, 1) == 1;
            rsp_ready   = $urandom_range(0, 9) < 7;
            #1;
            in_flight = (q.size() != 0);
            exp_r0 = 1'b0;
            exp_r1 = 1'b0;
            if (!rst && !in_flight) begin
                if (req0_valid && req1_valid) begin
                    exp_r0 = m_last;
                    exp_r1 = !m_last;
                end else begin
                    exp_r0 = req0_valid;
                    exp_r1 = req1_valid;
                end
            end
            exp_rv = in_flight && (m_age == 2);
            exp_op = (in_flight && m_age == 1) ? q[0].op : 6'h3F;
            exp_a  = (in_flight && m_age == 1) ? q[0].a  : 32'd0;
            check("rnd_readys", {req1_ready, req0_ready}, {exp_r1, exp_r0});
            check("rnd_rsp_valid", rsp_valid, exp_rv);
            check("rnd_alu_opcode", alu_opcode, exp_op);
            check("rnd_alu_a", alu_a, exp_a);
            if (exp_rv)
                check("rnd_rsp", {rsp_id, rsp_flags, rsp_result}, {q[0].id, q[0].out});
            check("rnd_cnt", {cnt0, cnt1}, {16'(m_cnt[0]), 16'(m_cnt[1])});
            check("rnd_narrow_cnt0", n_cnt0, 2'(m_cnt[0]));

            if (rst) begin
                q.delete();
                m_age  = 0;
                m_last = 1'b1;
                m_cnt  = '{0, 0};
            end else if (exp_r0 || exp_r1) begin
                t.id  = exp_r1;
                t.a   = exp_r1 ? req1_a : req0_a;
                t.b   = exp_r1 ? req1_b : req0_b;
                t.op  = exp_r1 ? req1_opcode : req0_opcode;
                t.cin = exp_r1 ? req1_cin : req0_cin;
                t.out = alu_fn(t.a, t.b, t.op, t.cin);
                q.push_back(t);
                m_age  = 1;
                m_last = t.id;
            end else if (in_flight) begin
                if (m_age == 1) begin
                    m_age = 2;
                end else if (rsp_ready) begin
                    m_cnt[q[0].id]++;
                    void'(q.pop_front());
                    m_age = 0;
                end
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: CNT_W, 16, width of each per-requester completed-operation counter.
REQ-002 Ports: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Ports: rst  input  1  reset, synchronous and active-high.
REQ-004 Ports: req0_valid / req1_valid  input  1  request pending from requester 0 / 1.
REQ-005 Ports: req0_ready / req1_ready  output  1  request accepted this cycle when also valid.
REQ-006 Ports: req0_a, req0_b / req1_a, req1_b  input  32  operands.
REQ-007 Ports: req0_opcode / req1_opcode  input  6  ALU opcode, using the team's 6-bit ALU encoding.
REQ-008 Ports: req0_cin / req1_cin  input  1  carry-in.
REQ-009 Ports: alu_a, alu_b  output  32  operands driven to the shared combinational ALU.
REQ-010 Ports: alu_opcode  output  6  opcode driven to the ALU.
REQ-011 Ports: alu_cin  output  1  carry-in driven to the ALU.
REQ-012 Ports: alu_result  input  32  ALU result.
REQ-013 Ports: alu_flags  input  4  ALU flags as {Zero, Sign, Carry, Overflow}.
REQ-014 Ports: rsp_valid  output  1  response available.
REQ-015 Ports: rsp_ready  input  1  consumer accepts the response.
REQ-016 Ports: rsp_id  output  1  requester that owns the response.
REQ-017 Ports: rsp_result  output  32  captured result.
REQ-018 Ports: rsp_flags  output  4  captured flags.
REQ-019 Ports: cnt0 / cnt1  output  CNT_W  completed-operation count per requester.

Function
REQ-020 FSM states SHALL be IDLE, EXEC and RESP.
REQ-021 In IDLE, req0_ready/req1_ready SHALL be asserted only for the granted requester, and only when that requester's valid is high; both readys SHALL be low in EXEC and RESP.
REQ-022 Grant SHALL be round-robin: with both valid, the requester not granted last wins; with one valid, it wins regardless; last_grant resets to 1, so req0 wins the first tie.
REQ-023 On accept, the block SHALL latch the operands, opcode, cin and id into a request register, update last_grant, and move IDLE->EXEC.
REQ-024 In EXEC, alu_* SHALL be driven from the request register; at the end of EXEC the block SHALL capture alu_result/alu_flags into the response register and move to RESP.
REQ-025 Outside EXEC, alu_a and alu_b SHALL be 0, alu_cin SHALL be 0, and alu_opcode SHALL be 6'b111111 (NOP).
REQ-026 In RESP, rsp_valid SHALL be 1 with rsp_id, rsp_result and rsp_flags held stable until rsp_ready.
REQ-027 A rsp_valid&rsp_ready handshake SHALL return the FSM to IDLE next cycle and increment the owner's counter.
REQ-028 Latency: accept at edge N, capture at edge N+1, rsp_valid high in cycle N+2.
REQ-029 Throughput: at most one operation per 3 cycles.
REQ-030 rsp_valid SHALL be low in IDLE and EXEC.
REQ-031 cnt0/cnt1 SHALL wrap modulo 2^CNT_W, all-ones -> 0, with no saturation.
REQ-032 Request inputs changing during EXEC or RESP SHALL NOT affect the in-flight operation.
REQ-033 A requester dropping valid in IDLE before being accepted SHALL lose nothing and change no state.
REQ-034 The block SHALL NOT interpret opcodes; unknown opcodes pass through and the captured ALU outputs are returned unchanged.

Reset
REQ-035 When rst is high at an edge, the block SHALL go to IDLE, set last_grant=1, clear the request/response registers, and set cnt0=cnt1=0; rst overrides every other input.
REQ-036 During reset, and in the cycle after it, outputs SHALL be: readys 0 during reset, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, alu_opcode=6'b111111, alu_a=alu_b=0.
REQ-037 Reset asserted during EXEC or RESP SHALL discard the in-flight operation: no response is issued and no counter increments.

Verification
REQ-038 Single op: req0 ADD, A=5, B=7 -> req0_ready in cycle 0; alu_opcode=000000 in cycle 1; in cycle 2 rsp_valid=1, rsp_id=0, rsp_result=12, rsp_flags=0000; cnt0=1 after handshake.
REQ-039 Tie after reset: both valid continuously with rsp_ready=1 -> grants 0,1,0,1 on successive ops, and cnt0=cnt1=2 after 4 ops.
REQ-040 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, both readys 0, no new accept; release -> IDLE next cycle.
REQ-041 Overflow flags: req1 ADD, A=32'h7FFFFFFF, B=1 -> rsp_result=32'h80000000, rsp_flags=0101, rsp_id=1.
REQ-042 Reset in EXEC: rst pulsed during EXEC -> no rsp_valid; counters 0; next op granted to req0 on a tie.
REQ-043 Wrap: CNT_W=2, 4 req0 ops -> cnt0 sequence 1,2,3,0.
